// File: rtl/tb_rd_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rd_stream_ctrl
//
// Bounded, restartable and abortable streaming-read sequencer. It sits between
// a memory with a combinational read port and an accelerator's valid/ready
// input.
//
// A start pulse in IDLE latches a base address, a word count N and a loop
// count L. The block then walks addresses base..base+N-1 and repeats that
// window L times, presenting one word per transfer. When the last word has
// been taken it pulses done_o for one cycle and returns to IDLE.
//
// Parameters
//   DataWidth   width of memory words and accelerator data
//   AddrWidth   width of memory addresses
//   CountWidth  width of word/loop counters and their config inputs
//
// Ports
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   start_i          start pulse, accepted only in IDLE
//   abort_i          abort the running transfer, effective only in STREAM
//   cfg_base_addr_i  first word address            (latched on accepted start)
//   cfg_num_words_i  words per pass, N              (latched on accepted start)
//   cfg_num_loops_i  number of passes, L            (latched on accepted start)
//   mem_rd_addr_o    address to the memory read port (latched base + word index)
//   mem_rd_data_i    combinational read data for mem_rd_addr_o
//   acc_data_o       stream data to the accelerator (pass-through of read data)
//   acc_valid_o      stream valid
//   acc_ready_i      accelerator ready
//   busy_o           high in STREAM and DONE
//   done_o           one-cycle completion pulse
//   word_cnt_o       current word index within the pass
//   loop_cnt_o       current pass index
// -----------------------------------------------------------------------------
module tb_rd_stream_ctrl #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned CountWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [AddrWidth-1:0]  cfg_base_addr_i,
  input  logic [CountWidth-1:0] cfg_num_words_i,
  input  logic [CountWidth-1:0] cfg_num_loops_i,
  output logic [AddrWidth-1:0]  mem_rd_addr_o,
  input  logic [DataWidth-1:0]  mem_rd_data_i,
  output logic [DataWidth-1:0]  acc_data_o,
  output logic                  acc_valid_o,
  input  logic                  acc_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CountWidth-1:0] word_cnt_o,
  output logic [CountWidth-1:0] loop_cnt_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDone   = 2'd2
  } state_e;

  state_e                state_q;
  logic [AddrWidth-1:0]  base_q;
  logic [CountWidth-1:0] num_words_q;
  logic [CountWidth-1:0] num_loops_q;
  logic [CountWidth-1:0] word_q;
  logic [CountWidth-1:0] loop_q;

  logic transfer;
  logic last_word;
  logic last_loop;
  logic cfg_empty;

  // STREAM is only ever entered with N >= 1 and L >= 1, so the "-1"
  // comparisons below never see an underflowed count while they matter.
  assign last_word = (word_q == num_words_q - CountWidth'(1));
  assign last_loop = (loop_q == num_loops_q - CountWidth'(1));
  assign cfg_empty = (cfg_num_words_i == '0) || (cfg_num_loops_i == '0);

  // Valid is combinational so an abort can withdraw it in the same cycle,
  // guaranteeing the aborted cycle never counts as a transfer.
  assign acc_valid_o = (state_q == StStream) && !abort_i;
  assign transfer    = acc_valid_o && acc_ready_i;

  // -------------------------------------------------------------------------
  // Sequencer: state, latched configuration and word/loop indices.
  // -------------------------------------------------------------------------
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments would let one update leak
  // into the next line's decision within the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      base_q      <= '0;
      num_words_q <= '0;
      num_loops_q <= '0;
      word_q      <= '0;
      loop_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          // start wins over a simultaneous abort: abort has no meaning here.
          if (start_i) begin
            base_q      <= cfg_base_addr_i;
            num_words_q <= cfg_num_words_i;
            num_loops_q <= cfg_num_loops_i;
            word_q      <= '0;
            loop_q      <= '0;
            state_q     <= cfg_empty ? StDone : StStream;
          end
        end

        StStream: begin
          if (abort_i) begin
            state_q <= StIdle;
            word_q  <= '0;
            loop_q  <= '0;
          end else if (transfer) begin
            if (!last_word) begin
              word_q <= word_q + CountWidth'(1);
            end else if (!last_loop) begin
              // Pass wrap happens on the transfer itself: no bubble between
              // the last word of one pass and the first word of the next.
              word_q <= '0;
              loop_q <= loop_q + CountWidth'(1);
            end else begin
              // Final word taken; indices keep their final values.
              state_q <= StDone;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs derived from registered state.
  // -------------------------------------------------------------------------
  // Address arithmetic is modulo 2^AddrWidth; a window running past the top
  // of the address space wraps silently to zero.
  assign mem_rd_addr_o = base_q + AddrWidth'(word_q);
  assign acc_data_o    = mem_rd_data_i;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);
  assign word_cnt_o    = word_q;
  assign loop_cnt_o    = loop_q;

endmodule

// File: tb/tb_tb_rd_stream_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tb_rd_stream_ctrl.
//
// A combinational memory model returns 0x100 + address. Each scenario pushes
// the expected (address, data, word index, loop index) sequence into a
// scoreboard queue when it issues the start, and pops one entry per observed
// transfer. Inputs are driven on the falling edge, outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_tb_rd_stream_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int Budget = 400;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [AW-1:0] cfg_base_addr_i = '0;
  logic [CW-1:0] cfg_num_words_i = '0;
  logic [CW-1:0] cfg_num_loops_i = '0;
  logic [AW-1:0] mem_rd_addr_o;
  logic [DW-1:0] mem_rd_data_i;
  logic [DW-1:0] acc_data_o;
  logic          acc_valid_o;
  logic          acc_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] word_cnt_o;
  logic [CW-1:0] loop_cnt_o;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [CW-1:0] word;
    logic [CW-1:0] loop;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    return 32'h0000_0100 + a;
  endfunction

  assign mem_rd_data_i = mem_model(mem_rd_addr_o);

  tb_rd_stream_ctrl #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .CountWidth(CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .cfg_base_addr_i(cfg_base_addr_i),
    .cfg_num_words_i(cfg_num_words_i),
    .cfg_num_loops_i(cfg_num_loops_i),
    .mem_rd_addr_o  (mem_rd_addr_o),
    .mem_rd_data_i  (mem_rd_data_i),
    .acc_data_o     (acc_data_o),
    .acc_valid_o    (acc_valid_o),
    .acc_ready_i    (acc_ready_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .word_cnt_o     (word_cnt_o),
    .loop_cnt_o     (loop_cnt_o)
  );

  // Scoreboard fill: the whole expected stream for one start.
  task automatic push_expected(input logic [AW-1:0] base, input int n, input int l);
    exp_t e;
    for (int j = 0; j < l; j++) begin
      for (int i = 0; i < n; i++) begin
        e.addr = base + AW'(i);
        e.data = mem_model(e.addr);
        e.word = CW'(i);
        e.loop = CW'(j);
        exp_q.push_back(e);
      end
    end
  endtask

  // Pulses start for one cycle; returns on the falling edge after acceptance.
  task automatic start_cfg(input logic [AW-1:0] base, input int n, input int l,
                           input bit with_abort);
    @(negedge clk_i);
    cfg_base_addr_i = base;
    cfg_num_words_i = CW'(n);
    cfg_num_loops_i = CW'(l);
    start_i         = 1'b1;
    abort_i         = with_abort;
    @(negedge clk_i);
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  // Full stream run: mode 0 keeps ready high, mode 1 uses ready 1,0,0,1,0,0...
  task automatic run_stream(input string name, input logic [AW-1:0] base,
                            input int n, input int l, input int mode,
                            input bit with_abort);
    exp_t e;
    int   k;
    bit   finished;
    push_expected(base, n, l);
    start_cfg(base, n, l, with_abort);
    finished = 1'b0;
    k = 0;
    while (!finished && k < Budget) begin
      acc_ready_i = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        n_cmp++;
        if ({acc_valid_o, busy_o, done_o} !== 3'b110) begin
          n_bad++;
          $display("FAIL %s_ctl k=%0d: valid/busy/done got %b expected 110", name, k,
                   {acc_valid_o, busy_o, done_o});
        end
        n_cmp++;
        if (mem_rd_addr_o !== e.addr) begin
          n_bad++;
          $display("FAIL %s_addr k=%0d: got %h expected %h", name, k, mem_rd_addr_o, e.addr);
        end
        n_cmp++;
        if (acc_data_o !== e.data) begin
          n_bad++;
          $display("FAIL %s_data k=%0d: got %h expected %h", name, k, acc_data_o, e.data);
        end
        n_cmp++;
        if ({word_cnt_o, loop_cnt_o} !== {e.word, e.loop}) begin
          n_bad++;
          $display("FAIL %s_idx k=%0d: word/loop got %0d/%0d expected %0d/%0d", name, k,
                   word_cnt_o, loop_cnt_o, e.word, e.loop);
        end
        if (acc_ready_i) void'(exp_q.pop_front());
      end else begin
        n_cmp++;
        if ({done_o, acc_valid_o, busy_o} !== 3'b101) begin
          n_bad++;
          $display("FAIL %s_done: done/valid/busy got %b expected 101", name,
                   {done_o, acc_valid_o, busy_o});
        end
        @(negedge clk_i);
        #1;
        n_cmp++;
        if ({done_o, acc_valid_o, busy_o} !== 3'b000) begin
          n_bad++;
          $display("FAIL %s_idle: done/valid/busy got %b expected 000", name,
                   {done_o, acc_valid_o, busy_o});
        end
        finished = 1'b1;
      end
      if (!finished) begin
        @(negedge clk_i);
        k++;
      end
    end
    n_cmp++;
    if (!finished) begin
      n_bad++;
      $display("FAIL %s_timeout: no completion within %0d cycles", name, Budget);
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({acc_valid_o, busy_o, done_o, word_cnt_o, loop_cnt_o, mem_rd_addr_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_vals: valid=%b busy=%b done=%b word=%0d loop=%0d addr=%h expected all 0",
               acc_valid_o, busy_o, done_o, word_cnt_o, loop_cnt_o, mem_rd_addr_o);
    end
    n_cmp++;
    if (acc_data_o !== 32'h0000_0100) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected %h", acc_data_o, 32'h0000_0100);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    n_cmp++;
    if ({acc_valid_o, busy_o, done_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_release: valid/busy/done got %b expected 000",
               {acc_valid_o, busy_o, done_o});
    end
  endtask

  task automatic test_empty;
    int nl [2][2] = '{'{0, 5}, '{5, 0}};
    for (int t = 0; t < 2; t++) begin
      start_cfg(32'd40, nl[t][0], nl[t][1], 1'b0);
      acc_ready_i = 1'b1;
      #1;
      n_cmp++;
      if ({done_o, acc_valid_o, busy_o} !== 3'b101) begin
        n_bad++;
        $display("FAIL empty%0d_done: done/valid/busy got %b expected 101", t,
                 {done_o, acc_valid_o, busy_o});
      end
      @(negedge clk_i);
      #1;
      n_cmp++;
      if ({done_o, acc_valid_o, busy_o} !== 3'b000) begin
        n_bad++;
        $display("FAIL empty%0d_idle: done/valid/busy got %b expected 000", t,
                 {done_o, acc_valid_o, busy_o});
      end
    end
  endtask

  task automatic test_abort;
    exp_t e;
    push_expected(32'd10, 8, 1);
    start_cfg(32'd10, 8, 1, 1'b0);
    acc_ready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (acc_valid_o !== 1'b1 || mem_rd_addr_o !== e.addr || acc_data_o !== e.data) begin
        n_bad++;
        $display("FAIL abort_pre k=%0d: valid=%b addr=%h data=%h expected 1/%h/%h", k,
                 acc_valid_o, mem_rd_addr_o, acc_data_o, e.addr, e.data);
      end
      @(negedge clk_i);
    end
    abort_i = 1'b1;
    #1;
    n_cmp++;
    if (acc_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_valid: got %b expected 0", acc_valid_o);
    end
    @(negedge clk_i);
    abort_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, done_o, acc_valid_o, word_cnt_o, loop_cnt_o} !== '0 ||
        mem_rd_addr_o !== 32'd10) begin
      n_bad++;
      $display("FAIL abort_idle: busy=%b done=%b valid=%b word=%0d loop=%0d addr=%h expected 0s, addr 0000000a",
               busy_o, done_o, acc_valid_o, word_cnt_o, loop_cnt_o, mem_rd_addr_o);
    end
    exp_q.delete();
    // Restart from base; start issued together with abort, which IDLE ignores.
    run_stream("restart", 32'd10, 2, 1, 0, 1'b1);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    push_expected(32'd20, 5, 3);
    start_cfg(32'd20, 5, 3, 1'b0);
    acc_ready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (mem_rd_addr_o !== e.addr) begin
        n_bad++;
        $display("FAIL rstmid_pre k=%0d: addr got %h expected %h", k, mem_rd_addr_o, e.addr);
      end
      @(negedge clk_i);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({acc_valid_o, busy_o, done_o, word_cnt_o, loop_cnt_o, mem_rd_addr_o} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_vals: valid=%b busy=%b done=%b word=%0d loop=%0d addr=%h expected all 0",
               acc_valid_o, busy_o, done_o, word_cnt_o, loop_cnt_o, mem_rd_addr_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    n_cmp++;
    if ({done_o, busy_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL rstmid_after: done/busy got %b expected 00", {done_o, busy_o});
    end
    exp_q.delete();
  endtask

  task automatic test_start_ignored;
    exp_t e;
    acc_ready_i = 1'b0;
    push_expected(32'd4, 3, 1);
    start_cfg(32'd4, 3, 1, 1'b0);
    // Stalled in STREAM: a new start with a different config must be ignored.
    cfg_base_addr_i = 32'd100;
    cfg_num_words_i = 16'd1;
    cfg_num_loops_i = 16'd1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    n_cmp++;
    if (mem_rd_addr_o !== 32'd4 || word_cnt_o !== 16'd0 || acc_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL ign_stream: addr=%h word=%0d valid=%b expected 00000004/0/1",
               mem_rd_addr_o, word_cnt_o, acc_valid_o);
    end
    @(negedge clk_i);
    acc_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (mem_rd_addr_o !== e.addr || acc_valid_o !== 1'b1) begin
        n_bad++;
        $display("FAIL ign_xfer k=%0d: addr=%h valid=%b expected %h/1", k,
                 mem_rd_addr_o, acc_valid_o, e.addr);
      end
      @(negedge clk_i);
    end
    #1;
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL ign_done: got %b expected 1", done_o);
    end
    // Start pulsed during DONE must not relaunch.
    cfg_base_addr_i = 32'd200;
    cfg_num_words_i = 16'd2;
    cfg_num_loops_i = 16'd2;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    n_cmp++;
    if ({busy_o, done_o, acc_valid_o} !== 3'b000 || mem_rd_addr_o !== 32'd6) begin
      n_bad++;
      $display("FAIL ign_in_done: busy/done/valid=%b addr=%h expected 000/00000006",
               {busy_o, done_o, acc_valid_o}, mem_rd_addr_o);
    end
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL ign_still_idle: busy got %b expected 0", busy_o);
    end
  endtask

  initial begin
    test_reset();
    run_stream("basic", 32'd4, 3, 2, 0, 1'b0);
    run_stream("stall", 32'd4, 3, 2, 1, 1'b0);
    run_stream("wrap", 32'hFFFF_FFFE, 4, 1, 0, 1'b0);
    run_stream("back_to_back", 32'd7, 2, 3, 0, 1'b0);
    test_empty();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
